// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes and instruction-field helpers shared by the CPU and its sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_MUL  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_NOT  = 3'b101,
    OP_DIS  = 3'b110,
    OP_HLT  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  localparam int OPC_W = 3;

  // Instruction word is {opcode, operand}; the opcode sits directly above the N-bit operand.
  function automatic int word_w(input int n);
    return n + OPC_W;
  endfunction

  function automatic int opc_lsb(input int n);
    return n;
  endfunction

  function automatic int result_w(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/cpu_program_sequencer_if.sv
// rtl/cpu_program_sequencer_if.sv - program-load, CPU command/result and display bus of the sequencer
interface cpu_program_sequencer_if #(
  parameter int N  = 5,
  parameter int AW = 4
);
  logic            PROG_WE;
  logic [AW-1:0]   PROG_ADDR;
  logic [N+2:0]    PROG_DATA;
  logic [2:0]      OPC;
  logic [N-1:0]    OPR;
  logic            START;
  logic [2*N:0]    CPU_RESULT;
  logic            DISP_VALID;
  logic [2*N:0]    DISP_DATA;

  modport master (
    input  PROG_WE, PROG_ADDR, PROG_DATA, CPU_RESULT,
    output OPC, OPR, START, DISP_VALID, DISP_DATA
  );

  modport slave (
    output PROG_WE, PROG_ADDR, PROG_DATA, CPU_RESULT,
    input  OPC, OPR, START, DISP_VALID, DISP_DATA
  );
endinterface

// File: rtl/seq_prog_ram.sv
// rtl/seq_prog_ram.sv - DEPTH x W program memory, one synchronous write port, asynchronous read
module seq_prog_ram #(
  parameter int W     = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_program_sequencer.sv
// rtl/cpu_program_sequencer.sv - issues stored {opcode, operand} words to the accumulator CPU until HLT
module cpu_program_sequencer
  import cpu_pkg::*;
#(
  parameter int N     = 5,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   RUN,
  cpu_program_sequencer_if.master bus,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   OVERRUN,
  output logic [AW-1:0]          PC
);
  localparam int W   = word_w(N);
  localparam int OLS = opc_lsb(N);
  localparam int RW  = result_w(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [2:0]    opc_q, opc_d;
  logic [N-1:0]  opr_q, opr_d;
  logic          start_q, start_d;
  logic          dis_pend_q, dis_pend_d;
  logic          dis_cap_q;
  logic          disp_valid_q;
  logic [RW-1:0] disp_data_q;
  logic          overrun_q, overrun_d;
  logic          end_q, end_d;
  logic          first_q, first_d;
  logic          run_q;
  logic [W-1:0]  word0_q;
  logic [W-1:0]  rd_word, iss_word;
  logic [AW-1:0] raddr;
  logic [2:0]    iss_opc;
  logic          prog_we_ok, run_rise;

  assign prog_we_ok = bus.PROG_WE && (state_q == ST_IDLE);
  assign run_rise   = RUN && !run_q;
  assign raddr      = (state_q == ST_IDLE) ? '0 : pc_q;

  seq_prog_ram #(.W(W), .AW(AW), .DEPTH(DEPTH)) u_ram (
    .CLK   (CLK),
    .we    (prog_we_ok),
    .waddr (bus.PROG_ADDR),
    .wdata (bus.PROG_DATA),
    .raddr (raddr),
    .rdata (rd_word)
  );

  // Word 0 is snapshotted on the start edge, so a write to address 0 in that same cycle misses this run.
  assign iss_word = first_q ? word0_q : rd_word;
  assign iss_opc  = iss_word[OLS +: 3];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opc_d      = opc_q;
    opr_d      = opr_q;
    start_d    = start_q;
    dis_pend_d = 1'b0;
    overrun_d  = overrun_q;
    end_d      = end_q;
    first_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_d = 1'b0;
        opc_d   = '0;
        opr_d   = '0;
        if (run_rise) begin
          pc_d      = '0;
          overrun_d = 1'b0;
          end_d     = 1'b0;
          first_d   = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        if (end_q) begin
          // Ran off the end of memory: close the program with a synthesized HLT.
          opc_d     = OP_HLT;
          opr_d     = '0;
          overrun_d = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          opc_d      = iss_opc;
          opr_d      = iss_word[N-1:0];
          dis_pend_d = (iss_opc == OP_DIS);
          if (pc_q == LAST_ADDR) begin
            end_d = (iss_opc != OP_HLT);
          end else begin
            pc_d = pc_q + 1'b1;
          end
          if (iss_opc == OP_HLT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        start_d = 1'b0;
        opc_d   = '0;
        opr_d   = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!RUN) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      opc_q        <= '0;
      opr_q        <= '0;
      start_q      <= 1'b0;
      dis_pend_q   <= 1'b0;
      dis_cap_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      overrun_q    <= 1'b0;
      end_q        <= 1'b0;
      first_q      <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      opc_q        <= opc_d;
      opr_q        <= opr_d;
      start_q      <= start_d;
      overrun_q    <= overrun_d;
      end_q        <= end_d;
      first_q      <= first_d;
      run_q        <= RUN;
      // DIS on OPC -> CPU samples it next edge -> result valid one edge later.
      dis_pend_q   <= dis_pend_d;
      dis_cap_q    <= dis_pend_q;
      disp_valid_q <= dis_cap_q;
      if (dis_cap_q) begin
        disp_data_q <= bus.CPU_RESULT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (state_q == ST_IDLE) begin
      word0_q <= rd_word;
    end
  end

  assign bus.OPC        = opc_q;
  assign bus.OPR        = opr_q;
  assign bus.START      = start_q;
  assign bus.DISP_VALID = disp_valid_q;
  assign bus.DISP_DATA  = disp_data_q;
  assign BUSY           = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign DONE           = (state_q == ST_DONE);
  assign OVERRUN        = overrun_q;
  assign PC             = pc_q;
endmodule
